// File: rtl/mult_err_monitor_if.sv
// Sample/handshake and statistics bundle between a multiplier sweep driver
// and mult_err_monitor.
interface mult_err_monitor_if #(
  parameter int CNT_W = 17,
  parameter int SUM_W = 32
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic [15:0]      r;
  logic             busy;
  logic             done;
  logic [SUM_W-1:0] sum_ed;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] smp_cnt;
  logic [15:0]      max_ed;
  logic [7:0]       max_a;
  logic [7:0]       max_b;

  modport master (
    output start, in_valid, a, b, r,
    input  in_ready, busy, done, sum_ed, err_cnt, smp_cnt, max_ed, max_a, max_b
  );

  modport slave (
    input  start, in_valid, a, b, r,
    output in_ready, busy, done, sum_ed, err_cnt, smp_cnt, max_ed, max_a, max_b
  );
endinterface

// File: rtl/mult_err_monitor.sv
// Error-statistics collector for 8x8 approximate multipliers: recomputes the
// exact product and accumulates ED sum, error count and worst case over a run.
module mult_err_monitor #(
  parameter int N_SAMPLES = 65536,
  parameter int CNT_W     = 17,
  parameter int SUM_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mult_err_monitor_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int EXT_W = ((SUM_W > 16) ? SUM_W : 16) + 1;
  localparam logic [EXT_W-1:0] SUM_MAX = EXT_W'({SUM_W{1'b1}});
  localparam logic [CNT_W-1:0] N_LIM   = CNT_W'(N_SAMPLES);
  localparam logic [CNT_W-1:0] N_LAST  = CNT_W'(N_SAMPLES - 1);

  function automatic logic [15:0] abs_diff(input logic [15:0] x, input logic [15:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] acc,
                                               input logic [15:0]      ed);
    logic [EXT_W-1:0] s;
    s = EXT_W'(acc) + EXT_W'(ed);
    if (s > SUM_MAX)
      return {SUM_W{1'b1}};
    return s[SUM_W-1:0];
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] acc_cnt;
  logic             drain_ph;
  logic             in_ready_i;
  logic             accept;
  logic             clr_stats;

  logic             vld_p1;
  logic [7:0]       a_p1;
  logic [7:0]       b_p1;
  logic [15:0]      r_p1;
  logic [15:0]      exact_p1;

  logic             vld_p2;
  logic [7:0]       a_p2;
  logic [7:0]       b_p2;
  logic [15:0]      ed_p2;

  logic [SUM_W-1:0] sum_ed_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] smp_cnt_q;
  logic [15:0]      max_ed_q;
  logic [7:0]       max_a_q;
  logic [7:0]       max_b_q;

  assign in_ready_i = (state == S_RUN) && (acc_cnt < N_LIM);
  assign accept     = bus.in_valid && in_ready_i;
  assign clr_stats  = bus.start && ((state == S_IDLE) || (state == S_DONE));

  // Run control: accept counter and IDLE/RUN/DRAIN/DONE sequencing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      acc_cnt  <= '0;
      drain_ph <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state   <= S_RUN;
            acc_cnt <= '0;
          end
        end
        S_RUN: begin
          if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
            if (acc_cnt == N_LAST) begin
              state    <= S_DRAIN;
              drain_ph <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          // Two cycles here let the last sample clear both pipeline stages
          if (drain_ph)
            state <= S_DONE;
          else
            drain_ph <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      vld_p2 <= vld_p1;
    end
  end

  // Stage 1: capture operands and approximate product, form exact product
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1     <= bus.a;
      b_p1     <= bus.b;
      r_p1     <= bus.r;
      exact_p1 <= {8'd0, bus.a} * {8'd0, bus.b};
    end
  end

  // Stage 2: error distance alongside the operands that produced it
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      a_p2  <= a_p1;
      b_p2  <= b_p1;
      ed_p2 <= abs_diff(exact_p1, r_p1);
    end
  end

  // Accumulation; strict greater-than keeps the earliest worst-case sample
  always_ff @(posedge clk) begin
    if (!rst_n || clr_stats) begin
      sum_ed_q  <= '0;
      err_cnt_q <= '0;
      smp_cnt_q <= '0;
      max_ed_q  <= '0;
      max_a_q   <= '0;
      max_b_q   <= '0;
    end else if (vld_p2) begin
      smp_cnt_q <= smp_cnt_q + CNT_W'(1);
      err_cnt_q <= err_cnt_q + CNT_W'(ed_p2 != 16'd0);
      sum_ed_q  <= sat_add(sum_ed_q, ed_p2);
      if (ed_p2 > max_ed_q) begin
        max_ed_q <= ed_p2;
        max_a_q  <= a_p2;
        max_b_q  <= b_p2;
      end
    end
  end

  assign bus.in_ready = in_ready_i;
  assign bus.busy     = (state == S_RUN) || (state == S_DRAIN);
  assign bus.done     = (state == S_DONE);
  assign bus.sum_ed   = sum_ed_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.smp_cnt  = smp_cnt_q;
  assign bus.max_ed   = max_ed_q;
  assign bus.max_a    = max_a_q;
  assign bus.max_b    = max_b_q;

endmodule

// File: tb/tb_mult_err_monitor.sv
// Bench for mult_err_monitor: two instances (long run / small-accumulator run)
// driven by directed and random sweeps, checked against a sample-list model.
module tb_mult_err_monitor;
  localparam int CW  = 17;
  localparam int N0  = 16;
  localparam int SW0 = 32;
  localparam int N1  = 4;
  localparam int SW1 = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic st0, st1, in_valid;
  logic [7:0]  a, b;
  logic [15:0] r;

  mult_err_monitor_if #(.CNT_W(CW), .SUM_W(SW0)) bus0 ();
  mult_err_monitor_if #(.CNT_W(CW), .SUM_W(SW1)) bus1 ();

  assign bus0.start = st0;
  assign bus0.in_valid = in_valid;
  assign bus0.a = a;
  assign bus0.b = b;
  assign bus0.r = r;
  assign bus1.start = st1;
  assign bus1.in_valid = in_valid;
  assign bus1.a = a;
  assign bus1.b = b;
  assign bus1.r = r;

  mult_err_monitor #(.N_SAMPLES(N0), .CNT_W(CW), .SUM_W(SW0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  mult_err_monitor #(.N_SAMPLES(N1), .CNT_W(CW), .SUM_W(SW1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  int sel = 0;
  logic        o_ready, o_busy, o_done;
  logic [31:0] o_sum;
  logic [CW-1:0] o_err, o_smp;
  logic [15:0] o_maxed;
  logic [7:0]  o_maxa, o_maxb;

  always_comb begin
    if (sel == 1) begin
      o_ready = bus1.in_ready; o_busy = bus1.busy; o_done = bus1.done;
      o_sum = 32'(bus1.sum_ed); o_err = bus1.err_cnt; o_smp = bus1.smp_cnt;
      o_maxed = bus1.max_ed; o_maxa = bus1.max_a; o_maxb = bus1.max_b;
    end else begin
      o_ready = bus0.in_ready; o_busy = bus0.busy; o_done = bus0.done;
      o_sum = bus0.sum_ed; o_err = bus0.err_cnt; o_smp = bus0.smp_cnt;
      o_maxed = bus0.max_ed; o_maxa = bus0.max_a; o_maxb = bus0.max_b;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  logic [7:0]  sa[64];
  logic [7:0]  sb[64];
  logic [15:0] sr[64];
  bit          sv[64];
  int          len;

  task automatic put(input int i, input int av, input int bv, input int rv, input bit v);
    sa[i] = av[7:0];
    sb[i] = bv[7:0];
    sr[i] = rv[15:0];
    sv[i] = v;
  endtask

  // mode 0: exact products only; mode 1: mix of exact, near misses and random r
  task automatic gen_random(input int n, input int mode);
    int ex, rv;
    len = n;
    for (int i = 0; i < n; i++) begin
      sa[i] = 8'($urandom_range(0, 255));
      sb[i] = 8'($urandom_range(0, 255));
      ex = int'(sa[i]) * int'(sb[i]);
      rv = ex;
      if (mode == 1) begin
        case ($urandom_range(0, 3))
          0: rv = ex;
          1: rv = ex + int'($urandom_range(1, 300));
          2: rv = ex - int'($urandom_range(1, 300));
          default: rv = int'($urandom_range(0, 65535));
        endcase
        if (rv < 0) rv = 0;
        if (rv > 65535) rv = 65535;
      end
      sr[i] = rv[15:0];
      sv[i] = (i >= 24) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 1) st1 = v; else st0 = v;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_ready"}, o_ready, 0);
    chk({pfx, "_busy"},  o_busy, 0);
    chk({pfx, "_done"},  o_done, 0);
    chk({pfx, "_sum"},   o_sum, 0);
    chk({pfx, "_err"},   o_err, 0);
    chk({pfx, "_smp"},   o_smp, 0);
    chk({pfx, "_maxed"}, o_maxed, 0);
    chk({pfx, "_maxa"},  o_maxa, 0);
    chk({pfx, "_maxb"},  o_maxb, 0);
  endtask

  int qa[$];
  int qb[$];
  int qr[$];

  // Starts a run on one instance, plays sa/sb/sr/sv, checks handshake and
  // completion timing every cycle, then checks final statistics.
  task automatic run(input string tag, input int which, input int n, input int sumw,
                     input int abort_at, input int restart_at);
    int acc, since;
    bit full;
    longint sum, errs, mx, ma, mb, ex, ed, satmax;
    sel = which;
    qa.delete(); qb.delete(); qr.delete();
    in_valid = 1'b0;
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, 1'b0);
    chk({tag, "_start_ready"}, o_ready, 1);
    chk({tag, "_start_busy"},  o_busy, 1);
    chk({tag, "_start_done"},  o_done, 0);
    chk({tag, "_start_smp"},   o_smp, 0);
    chk({tag, "_start_sum"},   o_sum, 0);
    chk({tag, "_start_maxed"}, o_maxed, 0);
    acc = 0; since = 0; full = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) return;
      in_valid = sv[i]; a = sa[i]; b = sb[i]; r = sr[i];
      if (i == restart_at) set_start(which, 1'b1);
      chk({tag, "_ready"}, o_ready, !full);
      chk({tag, "_done"},  o_done, full && since >= 3);
      chk({tag, "_busy"},  o_busy, !(full && since >= 3));
      if (sv[i] && acc < n) begin
        qa.push_back(int'(sa[i])); qb.push_back(int'(sb[i])); qr.push_back(int'(sr[i]));
        acc++;
        if (acc == n) begin full = 1'b1; since = 0; end
      end
      @(negedge clk);
      set_start(which, 1'b0);
      if (full) since++;
    end
    in_valid = 1'b0;
    for (int w = 0; w < 8 && !(full && since >= 3); w++) begin
      chk({tag, "_wready"}, o_ready, !full);
      chk({tag, "_wdone"},  o_done, 0);
      @(negedge clk);
      if (full) since++;
    end
    chk({tag, "_fin_done"},  o_done, 1);
    chk({tag, "_fin_busy"},  o_busy, 0);
    chk({tag, "_fin_ready"}, o_ready, 0);

    sum = 0; errs = 0; mx = 0; ma = 0; mb = 0;
    satmax = (64'd1 << sumw) - 1;
    for (int j = 0; j < qa.size(); j++) begin
      ex = longint'(qa[j]) * longint'(qb[j]);
      ed = (ex >= qr[j]) ? ex - qr[j] : qr[j] - ex;
      sum += ed;
      if (ed != 0) errs++;
      if (ed > mx) begin mx = ed; ma = qa[j]; mb = qb[j]; end
    end
    if (sum > satmax) sum = satmax;
    chk({tag, "_smp_cnt"}, o_smp, qa.size());
    chk({tag, "_err_cnt"}, o_err, errs);
    chk({tag, "_sum_ed"},  o_sum, sum);
    chk({tag, "_max_ed"},  o_maxed, mx);
    chk({tag, "_max_a"},   o_maxa, ma);
    chk({tag, "_max_b"},   o_maxb, mb);

    in_valid = 1'b1; a = 8'd1; b = 8'd1; r = 16'd0;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_hold_done"}, o_done, 1);
    chk({tag, "_hold_smp"},  o_smp, qa.size());
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  initial begin
    st0 = 1'b0; st1 = 1'b0; in_valid = 1'b0; a = '0; b = '0; r = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sel = 0; #1; chk_zero("rst0");
    sel = 1; #1; chk_zero("rst1");
    @(negedge clk);

    // Under- and over-estimates
    len = 4;
    put(0, 10, 10, 95, 1); put(1, 3, 3, 12, 1); put(2, 0, 7, 0, 1); put(3, 255, 255, 65025, 1);
    run("uo", 1, N1, SW1, -1, -1);
    chk("uo_sum_const", o_sum, 8);
    chk("uo_maxa_const", o_maxa, 10);

    // Tie rule: two samples with ED 7, earliest kept
    len = 4;
    put(0, 2, 4, 1, 1); put(1, 5, 5, 18, 1); put(2, 1, 1, 1, 1); put(3, 0, 0, 3, 1);
    run("tie", 1, N1, SW1, -1, -1);
    chk("tie_maxb_const", o_maxb, 4);

    // Backpressure: valid held high past the sample count
    len = 8;
    for (int i = 0; i < 8; i++) put(i, i + 3, 2 * i + 1, i * 50, 1);
    run("bp", 1, N1, SW1, -1, -1);

    // Bubbles between samples
    len = 9;
    for (int i = 0; i < 9; i++) put(i, 7 * i + 1, 11, 3 * i, (i % 2) == 0);
    run("bub", 1, N1, SW1, -1, -1);

    // Saturating 8-bit accumulator: ED 200 + 100
    len = 4;
    put(0, 20, 10, 0, 1); put(1, 10, 10, 0, 1); put(2, 6, 6, 36, 1); put(3, 9, 9, 81, 1);
    run("sat", 1, N1, SW1, -1, -1);
    chk("sat_sum_const", o_sum, 255);

    // Exact multiplier on the 16-sample instance
    gen_random(40, 0);
    run("exact", 0, N0, SW0, -1, -1);
    chk("exact_sum_zero", o_sum, 0);

    for (int k = 0; k < 4; k++) begin
      gen_random(40, 1);
      run("rnd", 0, N0, SW0, -1, -1);
    end

    // Start pulse during a run is ignored
    gen_random(40, 1);
    run("restart_in_run", 0, N0, SW0, -1, 5);

    // Reset mid-run aborts, then a fresh run
    gen_random(40, 1);
    for (int i = 0; i < 8; i++) sv[i] = 1'b1;
    run("abort", 0, N0, SW0, 8, -1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sel = 0; #1;
    chk_zero("midrst");
    @(negedge clk);
    chk("midrst_idle_done", o_done, 0);
    chk("midrst_idle_smp", o_smp, 0);
    gen_random(40, 1);
    run("post_rst", 0, N0, SW0, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
